// File: rtl/graphic_multi_ball.sv
// Multi-ball pixel colouriser: renders NUM_BALLS filled circles over a safe/background field
// with a 3-stage pipeline, per-frame position latching and per-frame overlap reporting.
module graphic_multi_ball #(
    parameter int SCREEN_WIDTH  = 800,
    parameter int SCREEN_HEIGHT = 600,
    parameter int NUM_BALLS     = 2,
    parameter int BALL_RADIUS   = 20,
    parameter logic [NUM_BALLS*12-1:0] BALL_COLORS = {12'h0FF, 12'hF00},
    parameter logic [11:0] SAFE_COLOR = 12'h0F0,
    parameter logic [11:0] BKG_COLOR  = 12'h00F,
    localparam int XW = $clog2(SCREEN_WIDTH),
    localparam int YW = $clog2(SCREEN_HEIGHT)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_frame_start,
    input  logic [NUM_BALLS*XW-1:0] i_ball_x,
    input  logic [NUM_BALLS*YW-1:0] i_ball_y,
    input  logic [NUM_BALLS-1:0]    i_ball_en,
    input  logic                    i_is_safe,
    input  logic                    i_disp_enbl,
    input  logic [10:0]             i_h_coord,
    input  logic [9:0]              i_v_coord,
    input  logic                    i_hsync,
    input  logic                    i_vsync,
    output logic [XW-1:0]           o_screen_x,
    output logic [YW-1:0]           o_screen_y,
    output logic                    o_is_pixel_valid,
    output logic [3:0]              o_red,
    output logic [3:0]              o_green,
    output logic [3:0]              o_blue,
    output logic                    o_hsync,
    output logic                    o_vsync,
    output logic                    o_overlap
);

    localparam logic [23:0] R2 = 24'(BALL_RADIUS * BALL_RADIUS);

    logic [NUM_BALLS*XW-1:0] sh_x_q;
    logic [NUM_BALLS*YW-1:0] sh_y_q;
    logic [NUM_BALLS-1:0]    sh_en_q;

    logic signed [11:0] dx_d [NUM_BALLS];
    logic signed [11:0] dy_d [NUM_BALLS];
    logic signed [11:0] dx_q [NUM_BALLS];
    logic signed [11:0] dy_q [NUM_BALLS];
    logic [23:0]        dist2_d [NUM_BALLS];
    logic [23:0]        dist2_q [NUM_BALLS];

    logic s1_safe_q, s1_de_q, s1_hs_q, s1_vs_q;
    logic s2_safe_q, s2_de_q, s2_hs_q, s2_vs_q;
    logic hs_q, vs_q;
    logic [11:0] colour_d, colour_q;
    logic        acc_d, acc_q, overlap_d, overlap_q;

    logic [NUM_BALLS-1:0] hit;
    logic [11:0]          hit_col;
    logic                 any_hit;
    logic [3:0]           hit_cnt;
    logic                 pix_overlap;

    assign o_screen_x       = i_h_coord[XW-1:0];
    assign o_screen_y       = i_v_coord[YW-1:0];
    assign o_is_pixel_valid = i_disp_enbl && (i_h_coord < 11'(SCREEN_WIDTH))
                              && (i_v_coord < 10'(SCREEN_HEIGHT));

    // Zero-extend both operands to 12 bits so left/above-centre pixels go negative, not wrap.
    always_comb begin
        for (int k = 0; k < NUM_BALLS; k++) begin
            dx_d[k] = 12'(i_h_coord) - 12'(sh_x_q[XW*k +: XW]);
            dy_d[k] = 12'(i_v_coord) - 12'(sh_y_q[YW*k +: YW]);
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_BALLS; k++) begin
            dist2_d[k] = 24'(dx_q[k]) * 24'(dx_q[k]) + 24'(dy_q[k]) * 24'(dy_q[k]);
        end
    end

    // Descending scan so the lowest-index hit ball has the final say.
    always_comb begin
        hit     = '0;
        hit_col = '0;
        any_hit = 1'b0;
        hit_cnt = '0;
        for (int k = NUM_BALLS - 1; k >= 0; k--) begin
            hit[k] = sh_en_q[k] && (dist2_q[k] <= R2);
            if (hit[k]) begin
                hit_col = BALL_COLORS[12*k +: 12];
                any_hit = 1'b1;
            end
            hit_cnt = hit_cnt + {3'b000, hit[k]};
        end
        if (!s2_de_q)       colour_d = 12'h000;
        else if (any_hit)   colour_d = hit_col;
        else if (s2_safe_q) colour_d = SAFE_COLOR;
        else                colour_d = BKG_COLOR;
        pix_overlap = s2_de_q && (hit_cnt >= 4'd2);
    end

    // A pixel overlapping on the frame_start cycle belongs to the frame that is starting.
    always_comb begin
        acc_d     = i_frame_start ? pix_overlap : (acc_q | pix_overlap);
        overlap_d = i_frame_start ? acc_q : overlap_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sh_x_q    <= '0;
            sh_y_q    <= '0;
            sh_en_q   <= '0;
            s1_safe_q <= 1'b0;
            s1_de_q   <= 1'b0;
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            s2_safe_q <= 1'b0;
            s2_de_q   <= 1'b0;
            s2_hs_q   <= 1'b0;
            s2_vs_q   <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            colour_q  <= '0;
            acc_q     <= 1'b0;
            overlap_q <= 1'b0;
            for (int k = 0; k < NUM_BALLS; k++) begin
                dx_q[k]    <= '0;
                dy_q[k]    <= '0;
                dist2_q[k] <= '0;
            end
        end else begin
            if (i_frame_start) begin
                sh_x_q  <= i_ball_x;
                sh_y_q  <= i_ball_y;
                sh_en_q <= i_ball_en;
            end
            s1_safe_q <= i_is_safe;
            s1_de_q   <= i_disp_enbl;
            s1_hs_q   <= i_hsync;
            s1_vs_q   <= i_vsync;
            s2_safe_q <= s1_safe_q;
            s2_de_q   <= s1_de_q;
            s2_hs_q   <= s1_hs_q;
            s2_vs_q   <= s1_vs_q;
            hs_q      <= s2_hs_q;
            vs_q      <= s2_vs_q;
            colour_q  <= colour_d;
            acc_q     <= acc_d;
            overlap_q <= overlap_d;
            for (int k = 0; k < NUM_BALLS; k++) begin
                dx_q[k]    <= dx_d[k];
                dy_q[k]    <= dy_d[k];
                dist2_q[k] <= dist2_d[k];
            end
        end
    end

    assign o_red     = colour_q[11:8];
    assign o_green   = colour_q[7:4];
    assign o_blue    = colour_q[3:0];
    assign o_hsync   = hs_q;
    assign o_vsync   = vs_q;
    assign o_overlap = overlap_q;

endmodule

// File: tb/tb_graphic_multi_ball.sv
// Directed bench for graphic_multi_ball: driver pushes expected {colour,hsync,vsync} per tagged
// pixel, a negedge monitor pops and compares when the tag reaches the output stage.
module tb_graphic_multi_ball;

    localparam int XW = 10;
    localparam int YW = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            frame_start;
    logic [2*XW-1:0] ball_x;
    logic [2*YW-1:0] ball_y;
    logic [1:0]      ball_en;
    logic            is_safe, disp_enbl, hsync, vsync;
    logic [10:0]     h_coord;
    logic [9:0]      v_coord;
    logic [XW-1:0]   screen_x;
    logic [YW-1:0]   screen_y;
    logic            pix_valid;
    logic [3:0]      red, green, blue;
    logic            o_hs, o_vs, overlap;

    int total = 0;
    int bad   = 0;

    logic [13:0] exp_q[$];
    int          id_q[$];
    int          pix_id = 0;
    logic        cur_tag = 1'b0;
    logic [2:0]  tag_pipe = 3'b000;
    logic [13:0] mon_exp, mon_got;
    int          mon_id;

    always #5 clk = ~clk;

    graphic_multi_ball dut (
        .i_clk(clk), .i_rst(rst), .i_frame_start(frame_start),
        .i_ball_x(ball_x), .i_ball_y(ball_y), .i_ball_en(ball_en),
        .i_is_safe(is_safe), .i_disp_enbl(disp_enbl),
        .i_h_coord(h_coord), .i_v_coord(v_coord),
        .i_hsync(hsync), .i_vsync(vsync),
        .o_screen_x(screen_x), .o_screen_y(screen_y), .o_is_pixel_valid(pix_valid),
        .o_red(red), .o_green(green), .o_blue(blue),
        .o_hsync(o_hs), .o_vsync(o_vs), .o_overlap(overlap)
    );

    // Tag travels alongside each pixel so the monitor knows which output cycles to check.
    always @(posedge clk) tag_pipe <= {tag_pipe[1:0], cur_tag};

    always @(negedge clk) begin
        if (tag_pipe[2]) begin
            total++;
            mon_got = {red, green, blue, o_hs, o_vs};
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pix_queue_empty got=%h want=queued entry", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_id  = id_q.pop_front();
                if (mon_got !== mon_exp) begin
                    bad++;
                    $display("FAIL pix%0d {rgb,hs,vs} got=%h want=%h", mon_id, mon_got, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic pix(input int h, input int v, input logic safe, input logic de,
                       input logic hs, input logic vs, input logic tag,
                       input logic [11:0] col, input logic ehs, input logic evs);
        h_coord   = 11'(h);
        v_coord   = 10'(v);
        is_safe   = safe;
        disp_enbl = de;
        hsync     = hs;
        vsync     = vs;
        cur_tag   = tag;
        if (tag) begin
            exp_q.push_back({col, ehs, evs});
            id_q.push_back(pix_id);
            pix_id++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pix(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    endtask

    // Drain the pipeline first so shadow updates never touch pixels still in flight.
    task automatic frame(input int x0, input int y0, input int x1, input int y1,
                         input logic [1:0] en);
        repeat (3) idle();
        ball_x      = {10'(x1), 10'(x0)};
        ball_y      = {10'(y1), 10'(y0)};
        ball_en     = en;
        frame_start = 1'b1;
        idle();
        frame_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0;
        ball_x = '0; ball_y = '0; ball_en = '0;
        is_safe = 1'b0; disp_enbl = 1'b0; hsync = 1'b0; vsync = 1'b0;
        h_coord = '0; v_coord = '0;

        // Reset held two cycles with live pixels and syncs high
        pix(400, 300, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0);
        chk("rst_rgb0", {20'd0, red, green, blue}, 32'h0);
        chk("rst_sync0", {30'd0, o_hs, o_vs}, 32'h0);
        chk("rst_ovl0", {31'd0, overlap}, 32'h0);
        pix(400, 300, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0);
        chk("rst_rgb1", {20'd0, red, green, blue}, 32'h0);
        chk("rst_sync1", {30'd0, o_hs, o_vs}, 32'h0);
        rst = 1'b0;
        pix(400, 300, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h00F, 1'b1, 1'b1);
        chk("post_rst_rgb", {20'd0, red, green, blue}, 32'h0);
        pix(400, 300, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0F0, 1'b1, 1'b1);
        chk("comb_screen_x", {22'd0, screen_x}, 32'd400);
        chk("comb_valid_in", {31'd0, pix_valid}, 32'd1);
        h_coord = 11'd800;
        #1 chk("comb_valid_edge", {31'd0, pix_valid}, 32'd0);

        // Radius edges around ball0 at (100,100)
        frame(100, 100, 0, 0, 2'b01);
        chk("ovl_after_rst", {31'd0, overlap}, 32'd0);
        pix(120, 100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'hF00, 1'b0, 1'b0);
        pix(120, 101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h00F, 1'b0, 1'b0);
        pix(80,  100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'hF00, 1'b0, 1'b0);
        pix(100, 80,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'hF00, 1'b0, 1'b0);
        pix(100, 79,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h00F, 1'b0, 1'b0);
        pix(100, 100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0);

        // Priority and safe zone
        frame(200, 200, 200, 200, 2'b11);
        pix(200, 200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'hF00, 1'b0, 1'b0);
        pix(400, 400, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h0F0, 1'b0, 1'b0);
        frame(200, 200, 200, 200, 2'b10);
        chk("ovl_priority_frame", {31'd0, overlap}, 32'd1);
        pix(200, 200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h0FF, 1'b0, 1'b0);

        // Shadow latch ignores mid-frame position changes
        frame(100, 100, 0, 0, 2'b01);
        chk("ovl_single_ball", {31'd0, overlap}, 32'd0);
        ball_x = {10'd0, 10'd300};
        pix(100, 100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'hF00, 1'b0, 1'b0);
        frame(300, 100, 0, 0, 2'b01);
        pix(100, 100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h00F, 1'b0, 1'b0);
        pix(300, 100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'hF00, 1'b0, 1'b0);

        // Overlap reported one frame late
        frame(300, 300, 330, 300, 2'b11);
        pix(315, 300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'hF00, 1'b0, 1'b0);
        frame(300, 300, 400, 300, 2'b11);
        chk("ovl_set", {31'd0, overlap}, 32'd1);
        pix(350, 300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h00F, 1'b0, 1'b0);
        pix(300, 300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'hF00, 1'b0, 1'b0);
        pix(400, 300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h0FF, 1'b0, 1'b0);
        frame(300, 300, 400, 300, 2'b11);
        chk("ovl_clear", {31'd0, overlap}, 32'd0);

        // Sync/colour alignment: every consecutive output cycle is checked
        pix(10,  10,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h00F, 1'b0, 1'b0);
        pix(10,  10,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h00F, 1'b0, 1'b0);
        pix(300, 300, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'hF00, 1'b1, 1'b1);
        pix(10,  10,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h00F, 1'b0, 1'b1);
        pix(10,  10,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h00F, 1'b0, 1'b0);

        repeat (4) idle();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
